mem_read_arbiter: RTL and testbench
===================================

// Module: mem_read_arbiter
// PURPOSE
//  Shares the single AXI read-address/read-data channel pair to memory between the I-cache
//  and D-cache refill engines. Issues one burst at a time and routes its data beats back to
//  the owner. Sits between both caches' refill ports and the memory AXI master ports.
//  The D-cache write channels bypass this block.
// PARAMETERS
//  LEN_WIDTH   4  width of ARLEN; ARLEN is a beat count (LINE_SIZE), not AXI len-1
//  CNT_WIDTH   5  beat down-counter width; must hold 2**LEN_WIDTH
// PORTS
//  clk               in   1     clock
//  rst_n             in   1     reset, synchronous, active-low
//  ic_read_address   if   -     axi_read_address.slave, I-cache requester (req 0)
//  ic_read_data      if   -     axi_read_data.slave, I-cache beat return
//  dc_read_address   if   -     axi_read_address.slave, D-cache requester (req 1)
//  dc_read_data      if   -     axi_read_data.slave, D-cache beat return
//  mem_read_address  if   -     axi_read_address.master to memory
//  mem_read_data     if   -     axi_read_data.master from memory
//  busy              out  1     burst in ADDR or DATA phase
//  owner             out  1     current/last granted requester (0=IC, 1=DC)
//  stray_beat        out  1     1-cycle pulse: memory beat arrived with no burst open
// BEHAVIOUR
//  Reset: state IDLE; busy=0, owner=0, last_grant=1 (IC wins first tie), stray_beat=0,
//   mem ARVALID=0, both requester ARREADY=0 and RVALID=0, beat counter=0.
//  States (ArbState): IDLE -> ADDR -> DATA -> IDLE.
//  IDLE: sample ic/dc ARVALID. None -> stay. One -> grant it. Both -> round-robin:
//   grant requester != last_grant. Register owner; go ADDR. Req->mem ARVALID latency 1 cycle.
//  ADDR: mem ARADDR/ARLEN/ARID/ARVALID = owner's fields (combinational mux);
//   owner ARREADY = mem ARREADY; non-owner ARREADY=0. On ARVALID&ARREADY: cnt<=ARLEN
//   (ARLEN==0 loads 1), go DATA. Owner drops ARVALID before handshake -> IDLE,
//   last_grant unchanged.
//  DATA: mem RREADY = owner RREADY; owner RVALID/RDATA/RID/RLAST = mem's; non-owner RVALID=0.
//   Each RVALID&RREADY: cnt--. Beat with cnt==1 -> IDLE same edge, last_grant<=owner.
//   Routing by registered owner only; RID is ignored.
//  Back-to-back: next grant evaluated in IDLE cycle after last beat; min gap 1 cycle.
//  Non-granted requester waits with ARVALID high; never dropped, starvation-free (2-way RR).
//  IDLE/ADDR: mem RREADY=1; any RVALID beat discarded, stray_beat pulses next cycle.
//  Reset mid-burst: immediate IDLE; beats still in flight drained as stray.
//  busy = (state != IDLE). owner holds value after burst ends.
// STRUCTURE
//  mips_core_pkg: enum ArbState {ARB_IDLE, ARB_ADDR, ARB_DATA}; localparams REQ_IC=0, REQ_DC=1.
//  Sub-module rr_arbiter_2: combinational 2-way round-robin (req[1:0], last_grant -> gnt,
//   gnt_valid). All state, counter and channel muxing stay in mem_read_arbiter.
// TESTING
//  1 Only DC: ARVALID, ARADDR=0x0100, ARLEN=4, ARID=8 -> mem ARVALID next cycle with same
//    fields; 4 beats 0xA0..0xA3 reach dc only; ic RVALID=0 throughout; busy low after beat 4.
//  2 IC and DC ARVALID same cycle after reset -> IC granted (owner=0); DC ARREADY=0 until
//    IC's 4th beat; DC issued in following ADDR phase, owner=1.
//  3 Both requesting continuously for 4 bursts -> grants alternate IC,DC,IC,DC.
//  4 Memory holds ARREADY=0 for 5 cycles -> mem ARVALID/ARADDR stable, owner unchanged,
//    ic/dc ARREADY=0 until ARREADY rises; then exactly one handshake.
//  5 DC RREADY low on beat 2 for 3 cycles -> mem RREADY low, cnt frozen at 3; beats
//    delivered in order, no loss or duplication.
//  6 rst_n low at beat 2 of 4, memory sends remaining 2 beats -> IDLE, no requester RVALID,
//    stray_beat pulses twice; new ARVALID then granted normally.

Source files
------------

// File: rtl/mips_core_pkg.sv
//------------------------------------------------------------------------------
// Module  : mips_core_pkg
// Purpose : Shared types and constants for the memory read arbiter slice.
//           ArbState  - arbiter burst phases (IDLE -> ADDR -> DATA -> IDLE)
//           REQ_IC/DC - requester indices used for grant and owner encoding
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mips_core_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } ArbState;

  localparam logic REQ_IC = 1'b0;
  localparam logic REQ_DC = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rr_arbiter_2.sv
//------------------------------------------------------------------------------
// Module  : rr_arbiter_2
// Purpose : Combinational two-way round-robin arbiter.
// Ports   : req[1:0]   in   request vector (bit 0 = IC, bit 1 = DC)
//           last_grant in   requester granted most recently
//           gnt        out  index of the winning requester
//           gnt_valid  out  at least one request present
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module rr_arbiter_2
  import mips_core_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       gnt,
  output logic       gnt_valid
);

  always_comb begin
    gnt_valid = |req;
    // On a tie the requester that did not win last time goes first;
    // otherwise the single active requester wins (IC when none).
    if (&req) begin
      gnt = ~last_grant;
    end else begin
      gnt = req[REQ_DC];
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_read_arbiter.sv
//------------------------------------------------------------------------------
// Module  : mem_read_arbiter
// Purpose : Shares the single AXI read-address / read-data channel pair to
//           memory between the I-cache (req 0) and D-cache (req 1) refill
//           engines. One burst is in flight at a time; its beats are routed
//           back to the registered owner only (RID is not used for routing).
// Ports   : clk, rst_n            clock, synchronous active-low reset
//           ic_ar* / ic_r*        I-cache read address / read data (slave side)
//           dc_ar* / dc_r*        D-cache read address / read data (slave side)
//           mem_ar* / mem_r*      memory read address / read data (master side)
//           busy                  burst in ADDR or DATA phase
//           owner                 current/last granted requester (0=IC, 1=DC)
//           stray_beat            1-cycle pulse: beat arrived with no burst open
//           ARLEN is a beat count; a value of 0 is treated as one beat.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_read_arbiter
  import mips_core_pkg::*;
#(
  parameter int LEN_WIDTH  = 4,
  parameter int CNT_WIDTH  = 5,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // I-cache requester
  input  logic                  ic_arvalid,
  output logic                  ic_arready,
  input  logic [ADDR_WIDTH-1:0] ic_araddr,
  input  logic [LEN_WIDTH-1:0]  ic_arlen,
  input  logic [ID_WIDTH-1:0]   ic_arid,
  output logic                  ic_rvalid,
  input  logic                  ic_rready,
  output logic [DATA_WIDTH-1:0] ic_rdata,
  output logic [ID_WIDTH-1:0]   ic_rid,
  output logic                  ic_rlast,
  // D-cache requester
  input  logic                  dc_arvalid,
  output logic                  dc_arready,
  input  logic [ADDR_WIDTH-1:0] dc_araddr,
  input  logic [LEN_WIDTH-1:0]  dc_arlen,
  input  logic [ID_WIDTH-1:0]   dc_arid,
  output logic                  dc_rvalid,
  input  logic                  dc_rready,
  output logic [DATA_WIDTH-1:0] dc_rdata,
  output logic [ID_WIDTH-1:0]   dc_rid,
  output logic                  dc_rlast,
  // Memory
  output logic                  mem_arvalid,
  input  logic                  mem_arready,
  output logic [ADDR_WIDTH-1:0] mem_araddr,
  output logic [LEN_WIDTH-1:0]  mem_arlen,
  output logic [ID_WIDTH-1:0]   mem_arid,
  input  logic                  mem_rvalid,
  output logic                  mem_rready,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic [ID_WIDTH-1:0]   mem_rid,
  input  logic                  mem_rlast,
  // Status
  output logic                  busy,
  output logic                  owner,
  output logic                  stray_beat
);

  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  ArbState               r_state;
  logic                  r_owner;
  logic                  r_last_grant;
  logic                  r_stray;
  logic [CNT_WIDTH-1:0]  r_cnt;

  logic                  w_gnt;
  logic                  w_gnt_valid;
  logic                  w_own_arvalid;
  logic [ADDR_WIDTH-1:0] w_own_araddr;
  logic [LEN_WIDTH-1:0]  w_own_arlen;
  logic [ID_WIDTH-1:0]   w_own_arid;
  logic                  w_own_rready;
  logic                  w_in_addr;
  logic                  w_in_data;
  logic                  w_beat;
  logic [CNT_WIDTH-1:0]  w_cnt_load;

  rr_arbiter_2 u_rr (
    .req        ({dc_arvalid, ic_arvalid}),
    .last_grant (r_last_grant),
    .gnt        (w_gnt),
    .gnt_valid  (w_gnt_valid)
  );

  // Owner's request fields, selected by the registered owner.
  always_comb begin
    if (r_owner == REQ_DC) begin
      w_own_arvalid = dc_arvalid;
      w_own_araddr  = dc_araddr;
      w_own_arlen   = dc_arlen;
      w_own_arid    = dc_arid;
      w_own_rready  = dc_rready;
    end else begin
      w_own_arvalid = ic_arvalid;
      w_own_araddr  = ic_araddr;
      w_own_arlen   = ic_arlen;
      w_own_arid    = ic_arid;
      w_own_rready  = ic_rready;
    end
  end

  assign w_in_addr  = (r_state == ARB_ADDR);
  assign w_in_data  = (r_state == ARB_DATA);
  assign w_cnt_load = (w_own_arlen == '0) ? c_cnt_one
                                          : {{(CNT_WIDTH-LEN_WIDTH){1'b0}}, w_own_arlen};

  // Address channel: only the owner sees the memory ARREADY.
  assign mem_arvalid = w_in_addr & w_own_arvalid;
  assign mem_araddr  = w_own_araddr;
  assign mem_arlen   = w_own_arlen;
  assign mem_arid    = w_own_arid;
  assign ic_arready  = w_in_addr & (r_owner == REQ_IC) & mem_arready;
  assign dc_arready  = w_in_addr & (r_owner == REQ_DC) & mem_arready;

  // Data channel: outside DATA, beats are accepted and thrown away so a
  // burst cut short by reset can drain.
  assign mem_rready = w_in_data ? w_own_rready : 1'b1;
  assign ic_rvalid  = w_in_data & (r_owner == REQ_IC) & mem_rvalid;
  assign dc_rvalid  = w_in_data & (r_owner == REQ_DC) & mem_rvalid;
  assign ic_rdata   = mem_rdata;
  assign ic_rid     = mem_rid;
  assign ic_rlast   = mem_rlast;
  assign dc_rdata   = mem_rdata;
  assign dc_rid     = mem_rid;
  assign dc_rlast   = mem_rlast;
  assign w_beat     = mem_rvalid & mem_rready;

  assign busy       = (r_state != ARB_IDLE);
  assign owner      = r_owner;
  assign stray_beat = r_stray;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= ARB_IDLE;
      r_owner      <= REQ_IC;
      r_last_grant <= REQ_DC;
      r_stray      <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_stray <= !w_in_data && mem_rvalid;
      case (r_state)
        ARB_IDLE: begin
          if (w_gnt_valid) begin
            r_owner <= w_gnt;
            r_state <= ARB_ADDR;
          end
        end
        ARB_ADDR: begin
          // A withdrawn request abandons the grant without charging the
          // round-robin history.
          if (!w_own_arvalid) begin
            r_state <= ARB_IDLE;
          end else if (mem_arready) begin
            r_cnt   <= w_cnt_load;
            r_state <= ARB_DATA;
          end
        end
        ARB_DATA: begin
          if (w_beat) begin
            r_cnt <= r_cnt - c_cnt_one;
            if (r_cnt == c_cnt_one) begin
              r_state      <= ARB_IDLE;
              r_last_grant <= r_owner;
            end
          end
        end
        default: r_state <= ARB_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_read_arbiter.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_read_arbiter
// Purpose : Randomized self-checking bench for mem_read_arbiter. Two requester
//           agents and a memory agent generate traffic; a transaction-level
//           model of the arbitration rules predicts grants, routing and strays.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_read_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Requester stimulus, index 0 = IC, 1 = DC
  logic          rq_valid [2];
  logic [AW-1:0] rq_addr  [2];
  logic [LW-1:0] rq_len   [2];
  logic [IW-1:0] rq_id    [2];
  logic          rq_rready[2];

  logic          ic_arvalid, ic_arready, ic_rvalid, ic_rready, ic_rlast;
  logic [AW-1:0] ic_araddr;
  logic [LW-1:0] ic_arlen;
  logic [IW-1:0] ic_arid, ic_rid;
  logic [DW-1:0] ic_rdata;
  logic          dc_arvalid, dc_arready, dc_rvalid, dc_rready, dc_rlast;
  logic [AW-1:0] dc_araddr;
  logic [LW-1:0] dc_arlen;
  logic [IW-1:0] dc_arid, dc_rid;
  logic [DW-1:0] dc_rdata;
  logic          mem_arvalid, mem_arready, mem_rvalid, mem_rready, mem_rlast;
  logic [AW-1:0] mem_araddr;
  logic [LW-1:0] mem_arlen;
  logic [IW-1:0] mem_arid, mem_rid;
  logic [DW-1:0] mem_rdata;
  logic          busy, owner, stray_beat;

  assign ic_arvalid = rq_valid[0];
  assign ic_araddr  = rq_addr[0];
  assign ic_arlen   = rq_len[0];
  assign ic_arid    = rq_id[0];
  assign ic_rready  = rq_rready[0];
  assign dc_arvalid = rq_valid[1];
  assign dc_araddr  = rq_addr[1];
  assign dc_arlen   = rq_len[1];
  assign dc_arid    = rq_id[1];
  assign dc_rready  = rq_rready[1];

  mem_read_arbiter dut (
    .clk (clk), .rst_n (rst_n),
    .ic_arvalid (ic_arvalid), .ic_arready (ic_arready), .ic_araddr (ic_araddr),
    .ic_arlen (ic_arlen), .ic_arid (ic_arid), .ic_rvalid (ic_rvalid),
    .ic_rready (ic_rready), .ic_rdata (ic_rdata), .ic_rid (ic_rid), .ic_rlast (ic_rlast),
    .dc_arvalid (dc_arvalid), .dc_arready (dc_arready), .dc_araddr (dc_araddr),
    .dc_arlen (dc_arlen), .dc_arid (dc_arid), .dc_rvalid (dc_rvalid),
    .dc_rready (dc_rready), .dc_rdata (dc_rdata), .dc_rid (dc_rid), .dc_rlast (dc_rlast),
    .mem_arvalid (mem_arvalid), .mem_arready (mem_arready), .mem_araddr (mem_araddr),
    .mem_arlen (mem_arlen), .mem_arid (mem_arid), .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready), .mem_rdata (mem_rdata), .mem_rid (mem_rid),
    .mem_rlast (mem_rlast),
    .busy (busy), .owner (owner), .stray_beat (stray_beat)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] beat_data(input logic [AW-1:0] a, input int i);
    return a ^ (DW'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
  endfunction

  // Reference model: phase 0 = bus free, 1 = address issued, 2 = data
  int            m_phase = 0;
  logic          m_last  = 1'b1;
  logic          m_owner = 1'b0;
  logic          m_stray_pend = 1'b0;
  int            m_left = 0;
  int            m_idx  = 0;
  logic [AW-1:0] m_addr = '0;
  logic [IW-1:0] m_id   = '0;
  int            n_stray = 0;

  // Handshakes the next rising edge will perform, for the agents
  logic          f_ar_rq[2];
  logic          f_mem_ar = 1'b0;
  logic          f_mem_r  = 1'b0;
  logic [AW-1:0] cap_addr;
  logic [LW-1:0] cap_len;
  logic [IW-1:0] cap_id;

  // Memory agent state (one burst outstanding at most)
  logic          mq_valid;
  logic [AW-1:0] mq_addr;
  logic [IW-1:0] mq_id;
  int            mq_len;
  int            mq_idx;

  // Inputs are stable from posedge+1, so values seen here are those the
  // next rising edge acts on.
  always @(negedge clk) begin
    f_ar_rq[0] = 1'b0;
    f_ar_rq[1] = 1'b0;
    f_mem_ar   = 1'b0;
    f_mem_r    = 1'b0;
    if (rst_n !== 1'b1) begin
      m_phase      = 0;
      m_last       = 1'b1;
      m_owner      = 1'b0;
      m_stray_pend = 1'b0;
    end else begin
      chk("busy",       busy,        m_phase != 0);
      chk("owner",      owner,       m_owner);
      chk("stray_beat", stray_beat,  m_stray_pend);
      chk("mem_arvalid", mem_arvalid, m_phase == 1);
      chk("ic_arready", ic_arready,  m_phase == 1 && m_owner == 1'b0 && mem_arready);
      chk("dc_arready", dc_arready,  m_phase == 1 && m_owner == 1'b1 && mem_arready);
      chk("mem_rready", mem_rready,  (m_phase == 2) ? rq_rready[m_owner] : 1'b1);
      chk("ic_rvalid",  ic_rvalid,   m_phase == 2 && m_owner == 1'b0 && mem_rvalid);
      chk("dc_rvalid",  dc_rvalid,   m_phase == 2 && m_owner == 1'b1 && mem_rvalid);
      if (stray_beat) n_stray++;

      f_ar_rq[0] = rq_valid[0] & ic_arready;
      f_ar_rq[1] = rq_valid[1] & dc_arready;
      f_mem_ar   = mem_arvalid & mem_arready;
      f_mem_r    = mem_rvalid & mem_rready;
      cap_addr   = mem_araddr;
      cap_len    = mem_arlen;
      cap_id     = mem_arid;

      m_stray_pend = (m_phase != 2) && mem_rvalid;
      case (m_phase)
        0: if (rq_valid[0] || rq_valid[1]) begin
             m_owner = (rq_valid[0] && rq_valid[1]) ? ~m_last : rq_valid[1];
             m_phase = 1;
           end
        1: begin
             chk("mem_araddr", mem_araddr, rq_addr[m_owner]);
             chk("mem_arlen",  mem_arlen,  rq_len[m_owner]);
             chk("mem_arid",   mem_arid,   rq_id[m_owner]);
             if (mem_arready) begin
               m_addr  = rq_addr[m_owner];
               m_id    = rq_id[m_owner];
               m_left  = (rq_len[m_owner] == '0) ? 1 : int'(rq_len[m_owner]);
               m_idx   = 0;
               m_phase = 2;
             end
           end
        default: if (mem_rvalid && rq_rready[m_owner]) begin
             chk("rdata", m_owner ? dc_rdata : ic_rdata, beat_data(m_addr, m_idx));
             chk("rid",   m_owner ? dc_rid   : ic_rid,   m_id);
             chk("rlast", m_owner ? dc_rlast : ic_rlast, m_left == 1);
             m_idx++;
             m_left--;
             if (m_left == 0) begin
               m_last  = m_owner;
               m_phase = 0;
             end
           end
      endcase
    end
  end

  // One clock of agent activity, applied just after the rising edge.
  task automatic step(input bit allow_new);
    @(posedge clk);
    #1;
    for (int r = 0; r < 2; r++) begin
      if (f_ar_rq[r]) rq_valid[r] = 1'b0;
      if (!rq_valid[r] && allow_new && $urandom_range(0, 2) == 0) begin
        rq_valid[r] = 1'b1;
        rq_addr[r]  = $urandom & 32'hFFFF_FFC0;
        rq_len[r]   = LW'($urandom_range(0, 5));
        rq_id[r]    = IW'($urandom);
      end
      rq_rready[r] = ($urandom_range(0, 3) != 0);
    end
    if (f_mem_r) begin
      mq_idx++;
      if (mq_idx >= mq_len) mq_valid = 1'b0;
    end
    if (f_mem_ar) begin
      mq_valid = 1'b1;
      mq_addr  = cap_addr;
      mq_id    = cap_id;
      mq_len   = (cap_len == '0) ? 1 : int'(cap_len);
      mq_idx   = 0;
    end
    if (!rst_n || !mq_valid) mem_rvalid = 1'b0;
    else if (!mem_rvalid || f_mem_r) mem_rvalid = ($urandom_range(0, 2) != 0);
    mem_rdata   = beat_data(mq_addr, mq_idx);
    mem_rid     = mq_id;
    mem_rlast   = (mq_idx == mq_len - 1);
    mem_arready = rst_n && !mq_valid && ($urandom_range(0, 2) == 0);
  endtask

  int guard;
  int exp_stray;
  int stray_base;

  initial begin
    for (int r = 0; r < 2; r++) begin
      rq_valid[r] = 1'b0; rq_addr[r] = '0; rq_len[r] = '0; rq_id[r] = '0;
      rq_rready[r] = 1'b0;
    end
    mem_arready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rid = '0;
    mem_rlast = 1'b0; mq_valid = 1'b0; mq_addr = '0; mq_id = '0; mq_len = 0; mq_idx = 0;
    rst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    @(negedge clk);
    chk("rst_busy",   busy, 0);
    chk("rst_owner",  owner, 0);
    chk("rst_arvalid", mem_arvalid, 0);
    chk("rst_stray",  stray_beat, 0);

    // Simultaneous requests right after reset: IC must win the first tie.
    step(0);
    rq_valid[0] = 1'b1; rq_addr[0] = 32'h0000_1000; rq_len[0] = 4'd4; rq_id[0] = 4'd1;
    rq_valid[1] = 1'b1; rq_addr[1] = 32'h0000_0100; rq_len[1] = 4'd4; rq_id[1] = 4'd8;
    step(0);
    step(0);
    chk("tie_owner_ic", owner, 0);
    chk("tie_dc_arready", dc_arready, 0);
    chk("tie_mem_addr", mem_araddr, 32'h0000_1000);

    for (int c = 0; c < 2500; c++) step(1);

    // Reset in the middle of a burst with at least two beats still owed.
    guard = 0;
    while (!(m_phase == 2 && m_idx >= 1 && m_left >= 2) && guard < 3000) begin
      step(1);
      guard++;
    end
    chk("mid_burst_found", guard < 3000, 1);
    exp_stray = m_left;
    rst_n = 1'b0;
    step(0);
    step(0);
    rst_n = 1'b1;
    stray_base = n_stray;
    guard = 0;
    while (mq_valid && guard < 200) begin
      step(0);
      guard++;
    end
    step(0);
    step(0);
    chk("drain_bounded", guard < 200, 1);
    chk("stray_count", n_stray - stray_base, exp_stray);

    for (int c = 0; c < 600; c++) step(1);

    // Let all outstanding traffic finish.
    guard = 0;
    while ((m_phase != 0 || rq_valid[0] || rq_valid[1]) && guard < 2000) begin
      step(0);
      guard++;
    end
    step(0);
    chk("final_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
